// File: rtl/serial_adder_if.sv
// Handshake/data bundle for the bit-serial adder.
// The requester drives start and operands; the adder returns results and status.
interface serial_adder_if #(
   parameter int WIDTH = 4
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b,
      input  sum, cout, ovf, busy, done
   );

   modport slave (
      input  start, a, b,
      output sum, cout, ovf, busy, done
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial two's complement adder, LSB first, one bit per clock.
// Fixed latency WIDTH+1 cycles from start capture to the done pulse.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic [CW-1:0]    cnt;
   logic             cy;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] res_nx;

   always_comb begin
      fa_s   = sa[0] ^ sb[0] ^ cy;
      fa_c   = (sa[0] & sb[0]) | (cy & (sa[0] ^ sb[0]));
      res_nx = {fa_s, res[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         cnt    <= '0;
         cy     <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  sa     <= bus.a;
                  sb     <= bus.b;
                  res    <= '0;
                  cnt    <= '0;
                  cy     <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               res <= res_nx;
               cy  <= fa_c;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  // cy is still the carry into the MSB here
                  sum_q  <= res_nx;
                  cout_q <= fa_c;
                  ovf_q  <= cy ^ fa_c;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal values 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The module SHALL have port a, input, WIDTH bits: first operand (addend), two's complement.
REQ-006 The module SHALL have port b, input, WIDTH bits: second operand, two's complement.
REQ-007 The module SHALL have port sum, output, WIDTH bits: result a+b modulo 2^WIDTH.
REQ-008 The module SHALL have port cout, output, 1 bit: unsigned carry out of the MSB.
REQ-009 The module SHALL have port ovf, output, 1 bit: signed overflow.
REQ-010 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 The module SHALL implement a three-state FSM (IDLE, RUN, DONE), registered, all outputs driven from flops.
REQ-013 In IDLE, start=1 at an edge SHALL capture a and b into internal shift registers, clear the carry flop, clear the bit counter, and move to RUN; busy=1 from that edge.
REQ-014 In RUN, each edge SHALL add one bit pair LSB-first with a 1-bit full adder (operand bits, registered carry), shift the sum bit into a result shift register, and update the carry flop.
REQ-015 After WIDTH RUN edges (bit WIDTH-1 processed), the FSM SHALL move to DONE; start edge k therefore gives done=1 after edge k+WIDTH+1, i.e. fixed latency WIDTH+1 cycles.
REQ-016 On the RUN-to-DONE edge, sum, cout and ovf SHALL load together: sum = full result, cout = final carry, ovf = (carry into MSB) XOR (carry out of MSB).
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, busy 0, then the FSM SHALL return to IDLE unconditionally.
REQ-018 sum, cout and ovf SHALL hold their last loaded value at all times other than the completion edge; intermediate bits SHALL never appear on sum.
REQ-019 start SHALL be ignored in RUN and DONE; no queuing; a and b changing after the capture edge SHALL not affect the result.
REQ-020 start held high continuously SHALL produce back-to-back operations, one per WIDTH+2 cycles (IDLE→RUN→…→DONE→IDLE→capture).
REQ-021 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, and clear counter, carry and shift registers.
REQ-023 rst SHALL take priority over start and over any FSM transition.
REQ-024 rst asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-025 The first start SHALL be accepted at the first edge with rst=0 and state IDLE.

Verification (WIDTH=4)
REQ-026 a=0011, b=0101, start pulse at edge k -> busy=1 after k..k+4, done=1 after edge k+5 only; sum=1000, cout=0, ovf=1.
REQ-027 a=1111, b=0001 -> sum=0000, cout=1, ovf=0; a=1000, b=1000 -> sum=0000, cout=1, ovf=1.
REQ-028 Inverse check against the 4-bit subtractor: for every a,b pair (256 cases), feed dif=a-b and b -> sum equals a.
REQ-029 start pulse with a=0010, b=0010 while busy, after capturing a=0001, b=0001 -> single done, sum=0010; operand changes during RUN ignored.
REQ-030 rst asserted two cycles into RUN -> all outputs 0 next cycle, no done pulse; subsequent start with a=0110, b=0001 -> sum=0111 after 5 cycles.
REQ-031 start held high for 20 cycles with fixed a=0100, b=0011 -> done pulses every 6 cycles, each with sum=0111, cout=0, ovf=0.
